// File: rtl/fetch_sequencer.sv
// fetch_sequencer: load/run/step/halt sequencing for the IF stage, sharing the IM port with the UART loader.
// Define CYCLE_COUNT_EN to build the enabled-fetch cycle counter; otherwise cycle_count is tied to 0.
module fetch_sequencer #(
  parameter int         ADDR_W      = 10,
  parameter int         DATA_W      = 32,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              hazard_stall,
  input  logic [DATA_W-1:0] instruc,
  output logic              if_enable,
  output logic              pc_write,
  output logic              pc_clear,
  output logic              im_sel,
  output logic              im_wea,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_din,
  output logic [2:0]        state,
  output logic              halted,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_imAddr;
  logic              r_fetchValid;
  logic              r_pcClear;
  logic              r_halted;
  logic              w_ldFire;
  logic              w_ldDone;
  logic              w_haltOpcode;
  logic              w_unusedInstrBits;

  // Only the opcode field of the fetched word matters to the sequencer.
  assign w_unusedInstrBits = ^instruc[DATA_W-7:0];

  assign ld_ready     = (r_state == S_LOAD);
  assign im_sel       = (r_state == S_LOAD);
  assign im_wea       = ld_ready && ld_valid;
  assign im_din       = ld_data;
  assign w_ldFire     = ld_valid && ld_ready;
  assign w_ldDone     = w_ldFire && (ld_last || (r_imAddr == {ADDR_W{1'b1}}));
  assign w_haltOpcode = r_fetchValid && (instruc[DATA_W-1 -: 6] == HALT_OPCODE);

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    if_enable = 1'b0;
    pc_write  = 1'b0;
    case (r_state)
      S_IDLE, S_HALTED: begin
        cmd_ready = 1'b1;
        // The word fetched by a single step lands here, one cycle after STEP.
        if (w_haltOpcode) begin
          w_next = S_HALTED;
        end else if (cmd_valid) begin
          case (cmd_op)
            OP_RUN:  w_next = S_RUN;
            OP_STEP: w_next = S_STEP;
            OP_LOAD: w_next = S_LOAD;
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        if (w_ldDone) w_next = S_IDLE;
      end
      S_RUN: begin
        cmd_ready = 1'b1;
        if (w_haltOpcode || (cmd_valid && (cmd_op == OP_HALT))) begin
          w_next = S_HALTED;
        end else begin
          if_enable = 1'b1;
          pc_write  = !hazard_stall;
        end
      end
      S_STEP: begin
        if_enable = 1'b1;
        pc_write  = !hazard_stall;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_imAddr     <= '0;
      r_fetchValid <= 1'b0;
      r_pcClear    <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_fetchValid <= if_enable;
      r_pcClear    <= w_ldDone;
      r_halted     <= (w_next == S_HALTED);
      if (w_ldDone) begin
        r_imAddr <= '0;
      end else if (w_ldFire) begin
        r_imAddr <= r_imAddr + 1'b1;
      end
    end
  end

`ifdef CYCLE_COUNT_EN
  logic [31:0] r_cycleCount;

  // Restarts for every new program so each load is profiled from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycleCount <= 32'd0;
    end else if ((w_next == S_LOAD) && (r_state != S_LOAD)) begin
      r_cycleCount <= 32'd0;
    end else if (if_enable && pc_write) begin
      r_cycleCount <= r_cycleCount + 32'd1;
    end
  end

  assign cycle_count = r_cycleCount;
`else
  assign cycle_count = 32'd0;
`endif

  assign state    = r_state;
  assign halted   = r_halted;
  assign pc_clear = r_pcClear;
  assign im_addr  = r_imAddr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a cycle-level behavioural model.
module tb_fetch_sequencer;

  localparam int M_IDLE   = 0;
  localparam int M_LOAD   = 1;
  localparam int M_RUN    = 2;
  localparam int M_STEP   = 3;
  localparam int M_HALTED = 4;
  localparam int LAST_ADDR = 1023;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmdValid = 1'b0;
  logic [1:0]  cmdOp = 2'b00;
  logic        cmdReady;
  logic        ldValid = 1'b0;
  logic [31:0] ldData = 32'd0;
  logic        ldLast = 1'b0;
  logic        ldReady;
  logic        hazardStall = 1'b0;
  logic [31:0] instruc = 32'd0;
  logic        ifEnable;
  logic        pcWrite;
  logic        pcClear;
  logic        imSel;
  logic        imWea;
  logic [9:0]  imAddr;
  logic [31:0] imDin;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] cycleCount;

  int checks = 0;
  int failures = 0;

  // Behavioural model of the sequencer as seen from its ports.
  int          mMode = M_IDLE;
  int          mWordsLoaded = 0;
  bit          mFetchedLastCycle = 1'b0;
  bit          mPcClear = 1'b0;
  bit          mHalted = 1'b0;
  logic [31:0] mCount = 32'd0;

  // Observations of DUT activity used by the directed scenarios.
  int weaSeen = 0;
  int pcWriteSeen = 0;
  int ifEnSeen = 0;
  int pcClearSeen = 0;
  int lastWeaAddr = -1;

  fetch_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmdValid),
    .cmd_op       (cmdOp),
    .cmd_ready    (cmdReady),
    .ld_valid     (ldValid),
    .ld_data      (ldData),
    .ld_last      (ldLast),
    .ld_ready     (ldReady),
    .hazard_stall (hazardStall),
    .instruc      (instruc),
    .if_enable    (ifEnable),
    .pc_write     (pcWrite),
    .pc_clear     (pcClear),
    .im_sel       (imSel),
    .im_wea       (imWea),
    .im_addr      (imAddr),
    .im_din       (imDin),
    .state        (state),
    .halted       (halted),
    .cycle_count  (cycleCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mMode = M_IDLE;
    mWordsLoaded = 0;
    mFetchedLastCycle = 1'b0;
    mPcClear = 1'b0;
    mHalted = 1'b0;
    mCount = 32'd0;
  endtask

  // Compares every output against the model for the current cycle, then advances the model one clock.
  task automatic checkOutput();
    bit haltSeen;
    bit loadEnds;
    bit eCmdReady, eLdReady, eIfEn, ePcWr, eImSel, eWea;
    int nextMode;
    haltSeen  = mFetchedLastCycle && (instruc[31:26] == 6'h3F);
    loadEnds  = 1'b0;
    eCmdReady = 1'b0;
    eLdReady  = 1'b0;
    eIfEn     = 1'b0;
    ePcWr     = 1'b0;
    eImSel    = 1'b0;
    eWea      = 1'b0;
    nextMode  = mMode;
    if (mMode == M_IDLE || mMode == M_HALTED) begin
      eCmdReady = 1'b1;
      if (haltSeen) nextMode = M_HALTED;
      else if (cmdValid && cmdOp == 2'd0) nextMode = M_RUN;
      else if (cmdValid && cmdOp == 2'd1) nextMode = M_STEP;
      else if (cmdValid && cmdOp == 2'd2) nextMode = M_LOAD;
    end else if (mMode == M_LOAD) begin
      eLdReady = 1'b1;
      eImSel   = 1'b1;
      eWea     = ldValid;
      loadEnds = ldValid && (ldLast || mWordsLoaded == LAST_ADDR);
      if (loadEnds) nextMode = M_IDLE;
    end else if (mMode == M_RUN) begin
      eCmdReady = 1'b1;
      if (haltSeen || (cmdValid && cmdOp == 2'd3)) nextMode = M_HALTED;
      else begin
        eIfEn = 1'b1;
        ePcWr = !hazardStall;
      end
    end else begin
      eIfEn = 1'b1;
      ePcWr = !hazardStall;
      nextMode = M_IDLE;
    end

    check("cmd_ready",   cmdReady,   eCmdReady);
    check("ld_ready",    ldReady,    eLdReady);
    check("if_enable",   ifEnable,   eIfEn);
    check("pc_write",    pcWrite,    ePcWr);
    check("pc_clear",    pcClear,    mPcClear);
    check("im_sel",      imSel,      eImSel);
    check("im_wea",      imWea,      eWea);
    check("im_addr",     imAddr,     mWordsLoaded);
    check("im_din",      imDin,      ldData);
    check("state",       state,      mMode);
    check("halted",      halted,     mHalted);
    check("cycle_count", cycleCount, mCount);

    if (imWea === 1'b1) begin
      weaSeen++;
      lastWeaAddr = int'(imAddr);
    end
    if (pcWrite === 1'b1) pcWriteSeen++;
    if (ifEnable === 1'b1) ifEnSeen++;
    if (pcClear === 1'b1) pcClearSeen++;

    mPcClear = loadEnds;
    if (loadEnds) mWordsLoaded = 0;
    else if (mMode == M_LOAD && ldValid) mWordsLoaded++;
`ifdef CYCLE_COUNT_EN
    if (nextMode == M_LOAD && mMode != M_LOAD) mCount = 32'd0;
    else if (eIfEn && ePcWr) mCount = mCount + 32'd1;
`endif
    mFetchedLastCycle = eIfEn;
    mHalted = (nextMode == M_HALTED);
    mMode = nextMode;
  endtask

  task automatic applyStimulus(input bit cv, input logic [1:0] op, input bit lv, input logic [31:0] ld,
                               input bit ll, input bit st, input logic [31:0] ins);
    @(negedge clock);
    cmdValid    = cv;
    cmdOp       = op;
    ldValid     = lv;
    ldData      = ld;
    ldLast      = ll;
    hazardStall = st;
    instruc     = ins;
    #1;
    checkOutput();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0000_0013);
  endtask

  task automatic command(input logic [1:0] op);
    applyStimulus(1'b1, op, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0000_0013);
  endtask

  // Asserts reset between clock edges and checks that the outputs collapse without waiting for an edge.
  task automatic doReset();
    @(negedge clock);
    cmdValid = 1'b0;
    ldValid = 1'b0;
    ldLast = 1'b0;
    hazardStall = 1'b0;
    instruc = 32'd0;
    #2 reset = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_if_enable", ifEnable, 0);
    check("rst_im_addr", imAddr, 0);
    check("rst_halted", halted, 0);
    modelReset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [31:0] randInstr;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    #1;
    check("init_state", state, 0);
    check("init_halted", halted, 0);
    check("init_cycle_count", cycleCount, 0);
    check("init_im_addr", imAddr, 0);

    // Reset landing in the middle of RUN.
    command(2'd0);
    repeat (4) idleCycle();
    doReset();

    // Reset landing in the middle of a load abandons it.
    command(2'd2);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 2'd0, 1'b1, 32'hA000_0000 + k, 1'b0, 1'b0, 32'd0);
    doReset();

    // RUN, with the HALT opcode arriving on the third fetch-valid cycle.
    command(2'd0);
    idleCycle();
    idleCycle();
    idleCycle();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'hFC00_0000);
    check("halt_detect_pc_write", pcWrite, 0);
    check("halt_detect_if_enable", ifEnable, 0);
    idleCycle();
    check("halt_state", state, 4);
    check("halt_flag", halted, 1);
    check("halt_pc_write", pcWrite, 0);

    // Two single steps, the second one stalled.
    command(2'd1);
    pcWriteSeen = 0;
    ifEnSeen = 0;
    idleCycle();
    command(2'd1);
    check("step1_state", state, 0);
    check("step1_halted_cleared", halted, 0);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0013);
    idleCycle();
    check("step2_state", state, 0);
    check("step_pc_write_pulses", pcWriteSeen, 1);
    check("step_if_enable_pulses", ifEnSeen, 2);

    // Four-word load terminated by ld_last.
    command(2'd2);
    weaSeen = 0;
    pcClearSeen = 0;
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 2'd0, 1'b1, 32'h2001_0005 + k, k == 3, 1'b0, 32'd0);
    check("load4_wea_count", weaSeen, 4);
    check("load4_last_addr", lastWeaAddr, 3);
    idleCycle();
    check("load4_state", state, 0);
    idleCycle();
    check("load4_pc_clear_pulses", pcClearSeen, 1);

    // RUN for ten cycles with two stalls, then a HALT command.
    command(2'd0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 2'd0, 1'b0, 32'd0, 1'b0, (k == 3) || (k == 7), 32'h0000_0013);
    command(2'd3);
    idleCycle();
    check("count_halt_state", state, 4);
`ifdef CYCLE_COUNT_EN
    check("count_after_run", cycleCount, 8);
`else
    check("count_after_run", cycleCount, 0);
`endif

    // Full-memory load with no ld_last stops at the top address.
    command(2'd2);
    weaSeen = 0;
    lastWeaAddr = -1;
    for (int k = 0; k < 1024; k++) applyStimulus(1'b0, 2'd0, 1'b1, $urandom, 1'b0, 1'b0, 32'd0);
    check("load_full_wea_count", weaSeen, 1024);
    check("load_full_last_addr", lastWeaAddr, 1023);
    idleCycle();
    check("load_full_state", state, 0);
    check("load_full_im_addr", imAddr, 0);
    check("load_full_pc_clear", pcClear, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset();
      end else begin
        if ($urandom_range(0, 7) == 0) randInstr = 32'hFC00_0000 | ($urandom & 32'h03FF_FFFF);
        else randInstr = (32'($urandom_range(0, 62)) << 26) | ($urandom & 32'h03FF_FFFF);
        applyStimulus($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                      $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, randInstr);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
